// File: rtl/usb_bot_pkg.sv
// Shared types and constants for the Bulk-Only-Transport initiator:
// FSM states, wrapper signatures, SCSI opcodes and the transfer-length rule.
package usb_bot_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CBW,
      ST_DATA_OUT,
      ST_DATA_IN,
      ST_CSW,
      ST_DONE
   } bot_state_t;

   localparam logic [31:0] CBW_SIGNATURE = 32'h4342_5355;  // "USBC" little-endian
   localparam logic [31:0] CSW_SIGNATURE = 32'h5342_5355;  // "USBS" little-endian
   localparam logic [7:0]  CB_LENGTH     = 8'h0A;

   localparam int CBW_BYTES = 31;
   localparam int CSW_BYTES = 13;

   localparam logic [7:0] OP_TEST_UNIT_READY = 8'h00;
   localparam logic [7:0] OP_REQUEST_SENSE   = 8'h03;
   localparam logic [7:0] OP_INQUIRY         = 8'h12;
   localparam logic [7:0] OP_READ_CAPACITY   = 8'h25;
   localparam logic [7:0] OP_READ10          = 8'h28;
   localparam logic [7:0] OP_WRITE10         = 8'h2A;

   function automatic logic is_rw(input logic [7:0] op);
      return (op == OP_READ10) || (op == OP_WRITE10);
   endfunction

   // Unknown opcodes travel host-to-device with no payload.
   function automatic logic is_data_in(input logic [7:0] op);
      return (op == OP_REQUEST_SENSE) || (op == OP_INQUIRY) ||
             (op == OP_READ_CAPACITY) || (op == OP_READ10);
   endfunction

   function automatic logic [31:0] xfer_len(input logic [7:0]  op,
                                            input logic [15:0] len,
                                            input int unsigned block_size);
      logic [31:0] n;
      case (op)
         OP_REQUEST_SENSE:      n = 32'd18;
         OP_INQUIRY:            n = 32'd36;
         OP_READ_CAPACITY:      n = 32'd8;
         OP_READ10, OP_WRITE10: n = 32'(len) * 32'(block_size);
         default:               n = 32'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/usb_bot_csw_parser.sv
// Collects the 13-byte Command Status Wrapper, checks signature and tag,
// and holds status/residue/error flags until the next command clears them.
module usb_bot_csw_parser
   import usb_bot_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        clear,
   input  logic        enable,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   input  logic [31:0] exp_tag,
   output logic        last,
   output logic [7:0]  status,
   output logic [31:0] residue,
   output logic        err_sig,
   output logic        err_tag
);

   logic [3:0]   count;
   logic [95:0]  head;   // first 12 bytes, byte 0 in bits [7:0]
   logic [103:0] frame;

   assign frame = {byte_data, head};
   assign last  = enable && byte_valid && (count == 4'(CSW_BYTES - 1));

   // NOTE: the header store is only 12 bytes, so it is reset with everything
   // else; an aborted wrapper can never leak stale bytes into the next one.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count   <= '0;
         head    <= '0;
         status  <= '0;
         residue <= '0;
         err_sig <= 1'b0;
         err_tag <= 1'b0;
      end else if (clear) begin
         count   <= '0;
         head    <= '0;
         status  <= '0;
         residue <= '0;
         err_sig <= 1'b0;
         err_tag <= 1'b0;
      end else if (enable && byte_valid) begin
         head  <= frame[103:8];
         count <= last ? 4'd0 : count + 4'd1;
         if (last) begin
            status  <= frame[103:96];
            residue <= frame[95:64];
            err_sig <= (frame[31:0] != CSW_SIGNATURE);
            err_tag <= (frame[63:32] != exp_tag);
         end
      end
   end

endmodule

// File: rtl/usb_msc_bot_initiator.sv
// Host-side Bulk-Only-Transport initiator: sends the CBW, moves the payload
// in either direction, then collects and checks the CSW.
module usb_msc_bot_initiator
   import usb_bot_pkg::*;
#(
   parameter int unsigned BLOCK_SIZE = 512,
   parameter int unsigned TIMEOUT    = 60000000,
   parameter int unsigned LUN        = 0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_opcode,
   input  logic [31:0] cmd_lba,
   input  logic [15:0] cmd_len,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic [7:0]  wdata,
   input  logic        wvalid,
   output logic        wready,
   output logic [7:0]  rdata,
   output logic        rvalid,
   output logic        done,
   output logic [7:0]  done_status,
   output logic [31:0] done_residue,
   output logic        err_sig,
   output logic        err_tag
);

   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT) - 32'd1;

   bot_state_t  state, state_next;

   logic [7:0]   op_q;
   logic [31:0]  lba_q;
   logic [15:0]  len_q;
   logic [31:0]  tag_q;
   logic [31:0]  xfer_q;
   logic         dir_in_q;
   logic [4:0]   cbw_idx;
   logic [31:0]  remaining;
   logic [31:0]  idle_cnt;
   logic         timed_out;

   logic         cmd_fire;
   logic         tmo_hit;
   logic         csw_last;
   logic [7:0]   csw_status;
   logic [127:0] cb_vec;
   logic [247:0] cbw_vec;
   logic [7:0]   cbw_byte;

   assign cmd_fire = (state == ST_IDLE) && cmd_valid;
   assign tmo_hit  = (TIMEOUT != 0) && !rx_valid && (idle_cnt == TMO_LAST);

   // Command block, byte 0 in the low bits; LBA and length are big-endian.
   always_comb begin
      cb_vec       = '0;
      cb_vec[7:0]  = op_q;
      if (is_rw(op_q)) begin
         cb_vec[23:16] = lba_q[31:24];
         cb_vec[31:24] = lba_q[23:16];
         cb_vec[39:32] = lba_q[15:8];
         cb_vec[47:40] = lba_q[7:0];
         cb_vec[63:56] = len_q[15:8];
         cb_vec[71:64] = len_q[7:0];
      end else begin
         cb_vec[39:32] = xfer_q[7:0];
      end
   end

   assign cbw_vec  = {cb_vec, CB_LENGTH, 8'(LUN), (dir_in_q ? 8'h80 : 8'h00),
                      xfer_q, tag_q, CBW_SIGNATURE};
   assign cbw_byte = cbw_vec[{cbw_idx, 3'b000} +: 8];

   // NOTE: every output of this block gets a default before the case, so no
   // path through it can infer a latch.
   always_comb begin
      state_next = state;
      cmd_ready  = 1'b0;
      tx_valid   = 1'b0;
      tx_data    = 8'h00;
      wready     = 1'b0;
      done       = 1'b0;
      case (state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_next = ST_CBW;
         end
         ST_CBW: begin
            tx_valid = 1'b1;
            tx_data  = cbw_byte;
            if (tx_ready && (cbw_idx == 5'(CBW_BYTES - 1))) begin
               if (xfer_q == 32'd0) state_next = ST_CSW;
               else if (dir_in_q)   state_next = ST_DATA_IN;
               else                 state_next = ST_DATA_OUT;
            end
         end
         ST_DATA_OUT: begin
            tx_valid = wvalid;
            tx_data  = wdata;
            wready   = tx_ready;
            if (wvalid && tx_ready && (remaining == 32'd1)) state_next = ST_CSW;
         end
         ST_DATA_IN: begin
            if (tmo_hit)                                   state_next = ST_DONE;
            else if (rx_valid && (remaining == 32'd1))     state_next = ST_CSW;
         end
         ST_CSW: begin
            if (csw_last || tmo_hit) state_next = ST_DONE;
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // NOTE: all clocked state below uses non-blocking assignments so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         op_q     <= '0;
         lba_q    <= '0;
         len_q    <= '0;
         tag_q    <= '0;
         xfer_q   <= '0;
         dir_in_q <= 1'b0;
      end else if (cmd_fire) begin
         op_q     <= cmd_opcode;
         lba_q    <= cmd_lba;
         len_q    <= cmd_len;
         tag_q    <= tag_q + 32'd1;
         xfer_q   <= xfer_len(cmd_opcode, cmd_len, BLOCK_SIZE);
         dir_in_q <= is_data_in(cmd_opcode);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cbw_idx   <= '0;
         remaining <= '0;
      end else begin
         if (cmd_fire)                               cbw_idx <= '0;
         else if ((state == ST_CBW) && tx_ready)     cbw_idx <= cbw_idx + 5'd1;

         if (cmd_fire)
            remaining <= xfer_len(cmd_opcode, cmd_len, BLOCK_SIZE);
         else if (((state == ST_DATA_OUT) && wvalid && tx_ready) ||
                  ((state == ST_DATA_IN) && rx_valid))
            remaining <= remaining - 32'd1;
      end
   end

   // Inactivity watchdog for the device-to-host phases.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idle_cnt  <= '0;
         timed_out <= 1'b0;
      end else begin
         if ((state_next != state) || rx_valid)
            idle_cnt <= '0;
         else if ((state == ST_DATA_IN) || (state == ST_CSW))
            idle_cnt <= idle_cnt + 32'd1;

         if (cmd_fire)
            timed_out <= 1'b0;
         else if (tmo_hit && ((state == ST_DATA_IN) || (state == ST_CSW)))
            timed_out <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= (state == ST_DATA_IN) && rx_valid;
         if ((state == ST_DATA_IN) && rx_valid) rdata <= rx_data;
      end
   end

   usb_bot_csw_parser u_csw (
      .clk        (clk),
      .rstn       (rstn),
      .clear      (cmd_fire),
      .enable     (state == ST_CSW),
      .byte_valid (rx_valid),
      .byte_data  (rx_data),
      .exp_tag    (tag_q),
      .last       (csw_last),
      .status     (csw_status),
      .residue    (done_residue),
      .err_sig    (err_sig),
      .err_tag    (err_tag)
   );

   assign done_status = (timed_out || err_sig || err_tag) ? 8'hFF : csw_status;

endmodule

// File: tb/tb_usb_msc_bot_initiator.sv
// Randomised scoreboard bench for usb_msc_bot_initiator: a driver issues
// commands and pushes expectations, a monitor pops and compares on outputs.
module tb_usb_msc_bot_initiator;

   localparam int unsigned BLOCK_SIZE = 512;
   localparam int unsigned TIMEOUT    = 100;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  cmd_opcode = '0;
   logic [31:0] cmd_lba = '0;
   logic [15:0] cmd_len = '0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic [7:0]  wdata = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [7:0]  rdata;
   logic        rvalid;
   logic        done;
   logic [7:0]  done_status;
   logic [31:0] done_residue;
   logic        err_sig;
   logic        err_tag;

   always #5 clk = ~clk;

   usb_msc_bot_initiator #(
      .BLOCK_SIZE (BLOCK_SIZE),
      .TIMEOUT    (TIMEOUT),
      .LUN        (0)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_opcode   (cmd_opcode),
      .cmd_lba      (cmd_lba),
      .cmd_len      (cmd_len),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .wdata        (wdata),
      .wvalid       (wvalid),
      .wready       (wready),
      .rdata        (rdata),
      .rvalid       (rvalid),
      .done         (done),
      .done_status  (done_status),
      .done_residue (done_residue),
      .err_sig      (err_sig),
      .err_tag      (err_tag)
   );

   typedef struct {
      logic [7:0]  status;
      logic [31:0] residue;
      logic        esig;
      logic        etag;
   } done_exp_t;

   logic [7:0] exp_tx[$];
   logic [7:0] exp_rd[$];
   done_exp_t  exp_done[$];

   int          checks = 0;
   int          errors = 0;
   int          tx_cnt = 0;
   int          done_cnt = 0;
   logic [31:0] tag_m = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s: unexpected event at %0t", name, $time);
   endtask

   // ---------------- reference model ----------------
   function automatic int m_xfer(input logic [7:0] op, input logic [15:0] len);
      case (op)
         8'h03:        return 18;
         8'h12:        return 36;
         8'h25:        return 8;
         8'h28, 8'h2A: return int'(len) * int'(BLOCK_SIZE);
         default:      return 0;
      endcase
   endfunction

   function automatic bit m_in(input logic [7:0] op);
      return (op == 8'h03) || (op == 8'h12) || (op == 8'h25) || (op == 8'h28);
   endfunction

   task automatic push_cbw(input logic [7:0] op, input logic [31:0] lba,
                           input logic [15:0] len, input logic [31:0] tag);
      logic [7:0]  b[31];
      logic [31:0] x;
      x = 32'(m_xfer(op, len));
      for (int i = 0; i < 31; i++) b[i] = 8'h00;
      b[0] = 8'h55; b[1] = 8'h53; b[2] = 8'h42; b[3] = 8'h43;
      for (int i = 0; i < 4; i++) begin
         b[4 + i] = 8'(tag >> (8 * i));
         b[8 + i] = 8'(x >> (8 * i));
      end
      b[12] = m_in(op) ? 8'h80 : 8'h00;
      b[14] = 8'h0A;
      b[15] = op;
      if (op == 8'h28 || op == 8'h2A) begin
         for (int i = 0; i < 4; i++) b[17 + i] = 8'(lba >> (24 - 8 * i));
         b[22] = len[15:8];
         b[23] = len[7:0];
      end else begin
         b[19] = x[7:0];
      end
      for (int i = 0; i < 31; i++) exp_tx.push_back(b[i]);
   endtask

   // ---------------- monitor ----------------
   logic       stall_prev = 1'b0;
   logic [7:0] stall_data = '0;

   always @(negedge clk) begin
      if (!rstn) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("tx_valid_hold", {31'd0, tx_valid}, 32'd1);
            check("tx_data_hold", {24'd0, tx_data}, {24'd0, stall_data});
         end
         stall_prev = tx_valid && !tx_ready;
         stall_data = tx_data;

         if (tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) flag("tx_extra_byte");
            else check($sformatf("tx_byte_%0d", tx_cnt), {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
            tx_cnt++;
         end
         if (rvalid) begin
            if (exp_rd.size() == 0) flag("rvalid_extra");
            else check("rdata", {24'd0, rdata}, {24'd0, exp_rd.pop_front()});
         end
         if (done) begin
            if (exp_done.size() == 0) flag("done_extra");
            else begin
               done_exp_t e;
               e = exp_done.pop_front();
               check("done_status", {24'd0, done_status}, {24'd0, e.status});
               check("done_residue", done_residue, e.residue);
               check("err_sig", {31'd0, err_sig}, {31'd0, e.esig});
               check("err_tag", {31'd0, err_tag}, {31'd0, e.etag});
            end
            done_cnt++;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         tx_ready = ($urandom_range(0, 1) == 1);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver ----------------
   task automatic wait_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tx(input int target);
      int n = 0;
      while (tx_cnt < target) begin
         wait_cycle();
         if (++n > 5000) begin flag("wait_tx_timeout"); return; end
      end
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (done_cnt < target) begin
         wait_cycle();
         if (++n > 1000) begin flag("wait_done_timeout"); return; end
      end
   endtask

   task automatic issue_cmd(input logic [7:0] op, input logic [31:0] lba, input logic [15:0] len);
      int n = 0;
      while (!cmd_ready) begin
         wait_cycle();
         if (++n > 1000) begin flag("cmd_ready_timeout"); return; end
      end
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_lba    = lba;
      cmd_len    = len;
      tag_m      = tag_m + 32'd1;
      push_cbw(op, lba, len, tag_m);
      wait_cycle();
      cmd_valid  = 1'b0;
      cmd_opcode = 8'($urandom);
      cmd_lba    = $urandom;
      cmd_len    = 16'($urandom);
      check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
      check("err_sig_cleared", {31'd0, err_sig}, 32'd0);
      check("err_tag_cleared", {31'd0, err_tag}, 32'd0);
      check("status_cleared", {24'd0, done_status}, 32'd0);
   endtask

   task automatic send_rx(input logic [7:0] b, input int gap);
      rx_valid = 1'b1;
      rx_data  = b;
      wait_cycle();
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      repeat (gap) wait_cycle();
   endtask

   task automatic send_data_in(input int n);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom);
         exp_rd.push_back(b);
         send_rx(b, $urandom_range(0, 3));
      end
   endtask

   task automatic drive_write(input int n);
      logic [7:0] pay[$];
      int         k = 0;
      int         guard = 0;
      logic       hs;
      for (int i = 0; i < n; i++) begin
         pay.push_back(8'($urandom));
         exp_tx.push_back(pay[i]);
      end
      wvalid = 1'b0;
      while (k < n) begin
         if (!wvalid && $urandom_range(0, 3) != 0) begin
            wvalid = 1'b1;
            wdata  = pay[k];
         end
         @(negedge clk);
         hs = wvalid && wready;
         wait_cycle();
         if (hs) begin k++; wvalid = 1'b0; end
         if (++guard > 20000) begin flag("write_stall"); break; end
      end
      wvalid = 1'b0;
   endtask

   // mode: 0 good wrapper, 1 wrong tag, 2 wrong signature
   task automatic send_csw(input int mode, output logic [7:0] exp_status);
      logic [31:0] sig, tg, res;
      logic [7:0]  st;
      done_exp_t   e;
      sig = 32'h5342_5355;
      tg  = tag_m;
      res = $urandom_range(0, 600);
      st  = 8'($urandom_range(0, 2));
      if (mode == 1) tg  = tag_m + 32'd1;
      if (mode == 2) sig = 32'h4342_5355;
      e.status  = (mode != 0) ? 8'hFF : st;
      e.residue = res;
      e.esig    = (mode == 2);
      e.etag    = (mode == 1);
      exp_done.push_back(e);
      exp_status = e.status;
      for (int i = 0; i < 4; i++) send_rx(8'(sig >> (8 * i)), $urandom_range(0, 2));
      for (int i = 0; i < 4; i++) send_rx(8'(tg  >> (8 * i)), $urandom_range(0, 2));
      for (int i = 0; i < 4; i++) send_rx(8'(res >> (8 * i)), $urandom_range(0, 2));
      send_rx(st, 0);
   endtask

   task automatic run_cmd(input logic [7:0] op, input logic [31:0] lba,
                          input logic [15:0] len, input int mode);
      int         n, base, d0;
      logic [7:0] st;
      n    = m_xfer(op, len);
      base = tx_cnt;
      d0   = done_cnt;
      issue_cmd(op, lba, len);
      if (n == 0) wait_tx(base + 31);
      else if (m_in(op)) begin
         wait_tx(base + 31);
         send_data_in(n);
      end else drive_write(n);
      send_csw(mode, st);
      wait_done(d0 + 1);
      check("rd_queue_drained", exp_rd.size(), 0);
      check("tx_queue_drained", exp_tx.size(), 0);
      check("status_held", {24'd0, done_status}, {24'd0, st});
      check("err_sig_sticky", {31'd0, err_sig}, (mode == 2) ? 32'd1 : 32'd0);
      check("err_tag_sticky", {31'd0, err_tag}, (mode == 1) ? 32'd1 : 32'd0);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
      check({tag, "_wready"}, {31'd0, wready}, 32'd0);
      check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd0);
      check({tag, "_rdata"}, {24'd0, rdata}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      check({tag, "_status"}, {24'd0, done_status}, 32'd0);
      check({tag, "_residue"}, done_residue, 32'd0);
      check({tag, "_err"}, {30'd0, err_sig, err_tag}, 32'd0);
   endtask

   logic [7:0] ops[7] = '{8'h00, 8'h03, 8'h12, 8'h25, 8'h28, 8'h2A, 8'h1B};

   initial begin
      int base, d0, n, m;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_quiet("reset");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      wait_cycle();
      check("idle_ready", {31'd0, cmd_ready}, 32'd1);

      run_cmd(8'h00, 32'h0, 16'h0, 0);                 // TUR, tag 1
      run_cmd(8'h28, 32'h1234_5678, 16'd2, 0);         // READ10 1024 bytes
      run_cmd(8'h2A, $urandom, 16'd1, 0);              // WRITE10 512 bytes
      run_cmd(8'h12, 32'h0, 16'h0, 1);                 // tag 4, CSW carries tag 5
      run_cmd(8'h03, 32'h0, 16'h0, 0);                 // next command clears err_tag

      // Inactivity abort: INQUIRY gets only 10 of 36 bytes.
      base = tx_cnt;
      d0   = done_cnt;
      issue_cmd(8'h12, 32'h0, 16'h0);
      wait_tx(base + 31);
      begin
         done_exp_t e;
         e.status = 8'hFF; e.residue = '0; e.esig = 1'b0; e.etag = 1'b0;
         exp_done.push_back(e);
      end
      for (int i = 0; i < 10; i++) begin
         logic [7:0] b;
         b = 8'($urandom);
         exp_rd.push_back(b);
         send_rx(b, (i == 9) ? 0 : $urandom_range(0, 3));
      end
      n = 0;
      while (!done && n < 300) begin wait_cycle(); n++; end
      check("timeout_cycles_in_window", {31'd0, (n >= 99 && n <= 101)}, 32'd1);
      wait_cycle();
      check("timeout_done_seen", done_cnt, d0 + 1);

      // Reset in the middle of DATA_IN: silent abort, tag restarts.
      base = tx_cnt;
      issue_cmd(8'h28, $urandom, 16'd1);
      wait_tx(base + 31);
      send_data_in(20);
      repeat (3) wait_cycle();
      rstn = 1'b0;
      @(negedge clk);
      check_quiet("midreset");
      repeat (2) wait_cycle();
      rstn  = 1'b1;
      tag_m = '0;
      exp_tx.delete();
      wait_cycle();
      check("post_reset_ready", {31'd0, cmd_ready}, 32'd1);
      check_quiet("post_reset");
      d0 = done_cnt;
      repeat (150) wait_cycle();
      check("no_done_after_reset", done_cnt, d0);
      run_cmd(8'h00, 32'h0, 16'h0, 0);                 // tag 1 again

      // Randomised commands, with a stray IN byte while idle before each.
      for (int i = 0; i < 10; i++) begin
         send_rx(8'($urandom), 1);
         m = $urandom_range(0, 5);
         run_cmd(ops[$urandom_range(0, 6)], $urandom, 16'($urandom_range(0, 1)),
                 (m == 4) ? 1 : (m == 5) ? 2 : 0);
      end

      repeat (5) wait_cycle();
      check("final_done_queue", exp_done.size(), 0);
      check("final_rd_queue", exp_rd.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
